// File: rtl/dl11_uart_ctrl_if.sv
// DL11 console bus plus UART-pair handshake signals.
// The master side is the CPU bus decoder together with the UART pair.
interface dl11_uart_ctrl_if;
  logic [1:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rx_irq;
  logic        tx_irq;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic        rx_clear;

  modport master (
    output addr, rd, wr, wdata, tx_ready, rx_data, rx_data_ready,
    input  rdata, rx_irq, tx_irq, tx_data, tx_send, rx_clear
  );
  modport slave (
    input  addr, rd, wr, wdata, tx_ready, rx_data, rx_data_ready,
    output rdata, rx_irq, tx_irq, tx_data, tx_send, rx_clear
  );
endinterface

// File: rtl/dl11_uart_ctrl.sv
// DL11-style console register block (RCSR/RBUF/XCSR/XBUF).
// It sequences one uart_tx and one uart_rx instance.
module dl11_uart_ctrl #(
  parameter logic [7:0] DATA_MASK = 8'hFF
) (
  input  logic clk,
  input  logic reset_n,
  dl11_uart_ctrl_if.slave bus
);
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY} tx_state_t;

  localparam logic [1:0] A_RCSR = 2'd0, A_RBUF = 2'd1, A_XCSR = 2'd2, A_XBUF = 2'd3;

  tx_state_t   tx_state, tx_nxt;
  logic        done, rie, ovr, rdy, tie;
  logic        done_nxt, rie_nxt, ovr_nxt, rdy_nxt, tie_nxt;
  logic [7:0]  rbuf;
  logic        xbuf_wr, rbuf_rd, accept, rdy_set;
  logic [15:0] rd_mux;

  always_comb begin
    tx_nxt  = tx_state;
    rdy_set = 1'b0;
    // Writes to XBUF are accepted only while RDY is set; otherwise the byte is dropped.
    xbuf_wr = bus.wr && (bus.addr == A_XBUF) && rdy && (tx_state == T_IDLE);
    unique case (tx_state)
      T_IDLE: if (xbuf_wr) tx_nxt = T_REQ;
      T_REQ:  if (!bus.tx_ready) tx_nxt = T_BUSY;
      T_BUSY: if (bus.tx_ready) begin
        tx_nxt  = T_IDLE;
        rdy_set = 1'b1;
      end
      default: tx_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    rbuf_rd  = bus.rd && (bus.addr == A_RBUF);
    // The rx_clear guard stops a second capture while uart_rx drops its flag.
    accept   = bus.rx_data_ready && !bus.rx_clear;
    rie_nxt  = (bus.wr && bus.addr == A_RCSR) ? bus.wdata[6] : rie;
    tie_nxt  = (bus.wr && bus.addr == A_XCSR) ? bus.wdata[6] : tie;
    rdy_nxt  = xbuf_wr ? 1'b0 : (rdy_set ? 1'b1 : rdy);
    done_nxt = done;
    ovr_nxt  = ovr;
    if (accept) begin
      // A simultaneous RBUF read consumes the old byte, so no overrun is reported.
      done_nxt = 1'b1;
      ovr_nxt  = rbuf_rd ? 1'b0 : done;
    end else if (rbuf_rd) begin
      done_nxt = 1'b0;
      ovr_nxt  = 1'b0;
    end
    rd_mux = 16'h0000;
    unique case (bus.addr)
      A_RCSR: rd_mux = {8'h00, done, rie, 6'b0};
      A_RBUF: rd_mux = {ovr, ovr, 6'b0, rbuf};
      A_XCSR: rd_mux = {8'h00, rdy, tie, 6'b0};
      A_XBUF: rd_mux = {8'h00, bus.tx_data};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state     <= T_IDLE;
      bus.tx_send  <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.rx_clear <= 1'b0;
      bus.rdata    <= 16'h0000;
      bus.rx_irq   <= 1'b0;
      bus.tx_irq   <= 1'b0;
      done         <= 1'b0;
      rie          <= 1'b0;
      ovr          <= 1'b0;
      rbuf         <= 8'h00;
      rdy          <= 1'b1;
      tie          <= 1'b0;
    end else begin
      tx_state     <= tx_nxt;
      bus.tx_send  <= (tx_nxt == T_REQ);
      if (xbuf_wr) bus.tx_data <= bus.wdata[7:0];
      if (accept) rbuf <= bus.rx_data & DATA_MASK;
      bus.rx_clear <= accept;
      if (bus.rd) bus.rdata <= rd_mux;
      done         <= done_nxt;
      ovr          <= ovr_nxt;
      rie          <= rie_nxt;
      tie          <= tie_nxt;
      rdy          <= rdy_nxt;
      bus.rx_irq   <= done_nxt & rie_nxt;
      bus.tx_irq   <= rdy_nxt & tie_nxt;
    end
  end
endmodule

// File: tb/tb_dl11_uart_ctrl.sv
// Directed bench for dl11_uart_ctrl; inputs change and outputs are sampled 1ns after posedge.
module tb_dl11_uart_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] rv;

  dl11_uart_ctrl_if bus ();
  dl11_uart_ctrl #(.DATA_MASK(8'h7F)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    bus.addr = a; bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    d = bus.rdata;
  endtask

  task automatic inject(input logic [7:0] b);
    bus.rx_data = b; bus.rx_data_ready = 1'b1;
    step();
    bus.rx_data_ready = 1'b0;
    step();
  endtask

  // Drives a full uart_tx frame: tx_ready falls, stays low a few cycles, rises.
  task automatic tx_frame(input logic [7:0] exp_byte);
    bus.tx_ready = 1'b0;
    step();
    chk("tx_send_busy", {15'b0, bus.tx_send}, 16'h0000);
    repeat (4) begin
      step();
      chk("tx_data_busy", {8'h00, bus.tx_data}, {8'h00, exp_byte});
    end
    bus.tx_ready = 1'b1;
    step();
  endtask

  initial begin
    bus.addr = 2'd0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wdata = 16'h0;
    bus.tx_ready = 1'b1; bus.rx_data = 8'h00; bus.rx_data_ready = 1'b0;
    #22 reset_n = 1'b1;
    step();

    // Reset state
    chk("rst_rdata", bus.rdata, 16'h0000);
    chk("rst_irqs", {14'b0, bus.tx_irq, bus.rx_irq}, 16'h0000);
    chk("rst_send", {7'b0, bus.tx_send, bus.tx_data}, 16'h0000);
    bus_rd(2'd2, rv); chk("rst_xcsr", rv, 16'h0080);
    bus_rd(2'd0, rv); chk("rst_rcsr", rv, 16'h0000);

    // Single transmit
    bus_wr(2'd3, 16'h0041);
    chk("tx_send_req", {15'b0, bus.tx_send}, 16'h0001);
    bus_rd(2'd2, rv); chk("xcsr_busy", rv, 16'h0000);
    chk("tx_send_hold", {15'b0, bus.tx_send}, 16'h0001);
    chk("tx_data_req", {8'h00, bus.tx_data}, 16'h0041);
    tx_frame(8'h41);
    bus_rd(2'd2, rv); chk("xcsr_done", rv, 16'h0080);
    chk("tx_data_after", {8'h00, bus.tx_data}, 16'h0041);

    // Second XBUF write while RDY=0 is dropped
    bus_wr(2'd3, 16'h0041);
    bus_wr(2'd3, 16'h0042);
    chk("drop_data", {8'h00, bus.tx_data}, 16'h0041);
    tx_frame(8'h41);
    chk("drop_no_resend", {15'b0, bus.tx_send}, 16'h0000);
    bus_rd(2'd3, rv); chk("xbuf_read", rv, 16'h0041);

    // TIE with RDY=1 raises tx_irq next cycle
    bus_wr(2'd2, 16'h0040);
    chk("tx_irq_set", {15'b0, bus.tx_irq}, 16'h0001);
    bus_rd(2'd2, rv); chk("xcsr_tie", rv, 16'h00C0);
    bus_wr(2'd2, 16'h0000);
    chk("tx_irq_clr", {15'b0, bus.tx_irq}, 16'h0000);

    // Receive with mask and interrupt; flag kept high one extra cycle
    bus_wr(2'd0, 16'h0040);
    bus.rx_data = 8'hC5; bus.rx_data_ready = 1'b1;
    step();
    chk("rx_clear_pulse", {15'b0, bus.rx_clear}, 16'h0001);
    chk("rx_irq_set", {15'b0, bus.rx_irq}, 16'h0001);
    step();
    chk("rx_clear_single", {15'b0, bus.rx_clear}, 16'h0000);
    bus.rx_data_ready = 1'b0;
    step();
    chk("rx_clear_idle", {15'b0, bus.rx_clear}, 16'h0000);
    bus_rd(2'd1, rv); chk("rbuf_masked", rv, 16'h0045);
    chk("rx_irq_clr", {15'b0, bus.rx_irq}, 16'h0000);
    bus_rd(2'd0, rv); chk("rcsr_after", rv, 16'h0040);

    // Overrun
    inject(8'h31);
    inject(8'h32);
    bus_rd(2'd1, rv); chk("rbuf_overrun", rv, 16'hC032);
    bus_rd(2'd1, rv); chk("rbuf_again", rv, 16'h0032);

    // Capture and RBUF read in the same cycle
    inject(8'h33);
    bus.rx_data = 8'h55; bus.rx_data_ready = 1'b1;
    bus_rd(2'd1, rv); chk("race_old_rbuf", rv, 16'h0033);
    bus.rx_data_ready = 1'b0;
    step();
    bus_rd(2'd0, rv); chk("race_rcsr", rv, 16'h00C0);
    bus_rd(2'd1, rv); chk("race_rbuf", rv, 16'h0055);

    // Read and write in the same cycle returns pre-write value
    bus.addr = 2'd2; bus.wdata = 16'h0040; bus.wr = 1'b1; bus.rd = 1'b1;
    step();
    bus.wr = 1'b0; bus.rd = 1'b0;
    chk("rdwr_old", bus.rdata, 16'h0080);
    bus_rd(2'd2, rv); chk("rdwr_new", rv, 16'h00C0);

    // Async reset during T_REQ
    bus_wr(2'd3, 16'h007E);
    chk("rst_req_send", {15'b0, bus.tx_send}, 16'h0001);
    #2 reset_n = 1'b0;
    #1 chk("async_send", {15'b0, bus.tx_send}, 16'h0000);
    chk("async_irq", {14'b0, bus.tx_irq, bus.rx_irq}, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    step();
    bus_rd(2'd2, rv); chk("post_rst_xcsr", rv, 16'h0080);
    chk("post_rst_send", {15'b0, bus.tx_send}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
